keypad_operand_entry: RTL and testbench
=======================================

# keypad_operand_entry

Downstream consumer of the 4x4 keypad scanner. Takes the scanner's debounced `key_code`/`key_pulse` events and assembles two decimal operands digit by digit. It drives the operand currently being entered to the 7-segment display path as BCD. When the operator confirms with `#`, it converts both operands to binary with a sequential Horner loop and hands them to the arithmetic stage over a valid/ready handshake.

## Interface
- `MAX_DIGITS`, 3, maximum decimal digits per operand (1..4)
- `BIN_W`, 10, binary operand width; must satisfy 2^BIN_W > 10^MAX_DIGITS - 1
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `key_code`  in  4  scanner key index, row*4+col; valid only when `key_pulse`=1
- `key_pulse`  in  1  one-cycle new-key event
- `op_ready`  in  1  downstream accepts operands
- `op_valid`  out  1  operands A/B valid
- `op_a`  out  BIN_W  operand A, binary
- `op_b`  out  BIN_W  operand B, binary
- `disp_bcd`  out  4*MAX_DIGITS  BCD digits of the operand on display; LSD in [3:0]
- `disp_cnt`  out  $clog2(MAX_DIGITS+1)  digits entered in the displayed operand
- `disp_sel`  out  1  0 = operand A shown, 1 = operand B shown

## Operation
- Key map by code:
  - Digits: 0→1, 1→2, 2→3, 4→4, 5→5, 6→6, 8→7, 9→8, 10→9, 13→0.
  - Commands: 3 = `A` (next operand), 12 = `*` (clear), 14 = `#` (equals), 7 = `B` (backspace, see Configuration).
  - Codes 11 and 15 are ignored always.
- Each operand is held internally as BCD plus a digit count.
- Digit entry shifts the BCD left one nibble, inserts the new digit in the LSD, and increments the count.
- Digits arriving when the count equals MAX_DIGITS are ignored. A leading `0` counts as a digit.
- States:
  - **S_A**: digits go into A. `A` with a_cnt>0 → S_B. `A` with a_cnt=0 is ignored. `#` is ignored.
  - **S_B**: digits go into B. `#` with b_cnt>0 → S_CONV. `#` with b_cnt=0 is ignored. `A` is ignored.
  - **S_CONV**: 2*MAX_DIGITS steps. Steps 1..MAX_DIGITS process A's digits MSD first; the remaining steps process B's. Each step is acc ← acc*10 + digit, computed at BIN_W width. All keys are ignored.
  - **S_OUT**: `op_valid`=1; `op_a`/`op_b` held stable. On `op_valid && op_ready` → S_A with both operands' BCD and counts cleared. All keys, including `*`, are ignored, so valid is never withdrawn.
- `*` in S_A or S_B: clear both operands' BCD and counts, then go to S_A.
- `disp_sel`: 0 in S_A, 1 in S_B/S_CONV/S_OUT. `disp_bcd`/`disp_cnt` mirror the selected operand.
- `op_a`/`op_b` are loaded only on the final S_CONV step. Otherwise they hold their previous values.

## Timing
- All outputs are registered.
- Reset values: `op_valid`=0, `op_a`=0, `op_b`=0, `disp_bcd`=0, `disp_cnt`=0, `disp_sel`=0, state S_A.
- `rst` forces reset values immediately (asynchronous assertion) from any state, including mid-S_CONV and S_OUT.
- A `key_pulse` sampled at edge E updates `disp_*` and state at E.
- For `#` sampled at edge E0:
  - State is S_CONV after E0.
  - Conversion steps occur at E1..E(2*MAX_DIGITS).
  - `op_a`/`op_b` load, and `op_valid` rises, at E(2*MAX_DIGITS) (6 cycles for the default).
- Handshake completes at the first edge with `op_valid`=`op_ready`=1. `op_valid` is 0 after that edge.
- `op_ready` high before `op_valid` is allowed and has no effect.
- A `key_pulse` in the same cycle as handshake completion is ignored.

## Configuration
- `KEYPAD_BACKSPACE_EN` defined:
  - Key `B` (code 7) in S_A/S_B shifts the current operand's BCD right one nibble (zero-filling the MSD) and decrements its count.
  - `B` with count 0 is ignored.
  - `B` in S_B never returns to S_A.
- Undefined: code 7 is ignored in all states.

## Test plan
- Reset: assert `rst` for 2 cycles → all outputs 0, `disp_sel`=0; key pulses during reset produce no change.
- Normal flow: keys 1,2,3,A,4,5,# with `op_ready`=0:
  - `op_valid` rises 6 cycles after `#`, with `op_a`=123, `op_b`=45.
  - Outputs stay stable for 10 cycles.
  - Raising `op_ready` → `op_valid`=0 next edge, `disp_sel`=0, `disp_bcd`=0.
- Saturation: keys 9,9,9,7 → `disp_bcd`=0x999, `disp_cnt`=3; then A,0,0,1,# → `op_a`=999, `op_b`=1.
- Ignored keys and clear:
  - `#` in S_A and `A` with no digits → no state change.
  - Keys 5,A,6,* → S_A, `disp_bcd`=0, `disp_cnt`=0.
  - `*` while `op_valid`=1 → `op_valid` stays 1.
- Backspace: keys 1,2,B:
  - With `KEYPAD_BACKSPACE_EN` defined → `disp_bcd`=0x001, `disp_cnt`=1.
  - Without it → `disp_bcd`=0x012, `disp_cnt`=2.
- Reset mid-conversion: assert `rst` 3 cycles after `#` → `op_valid` never rises, all outputs 0, next entry sequence works normally.

Source files
------------

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: builds two decimal operands from scanner key events and
// converts them to binary for the arithmetic stage. Optional backspace: KEYPAD_BACKSPACE_EN.
module keypad_operand_entry #(
    parameter int MAX_DIGITS = 3,
    parameter int BIN_W      = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         key_code,
    input  logic                               key_pulse,
    input  logic                               op_ready,
    output logic                               op_valid,
    output logic [BIN_W-1:0]                   op_a,
    output logic [BIN_W-1:0]                   op_b,
    output logic [4*MAX_DIGITS-1:0]            disp_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    disp_cnt,
    output logic                               disp_sel
);

    localparam int DW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int SW = $clog2(2 * MAX_DIGITS);
    localparam logic [CW-1:0] CNT_MAX     = CW'(MAX_DIGITS);
    localparam logic [SW-1:0] STEP_A_LAST = SW'(MAX_DIGITS - 1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(2 * MAX_DIGITS - 1);

    typedef enum logic [1:0] {S_A, S_B, S_CONV, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       a_bcd_q, a_bcd_d, b_bcd_q, b_bcd_d;
    logic [CW-1:0]       a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic [2*DW-1:0]     conv_sh_q, conv_sh_d;
    logic [SW-1:0]       step_q, step_d;
    logic [BIN_W-1:0]    acc_q, acc_d, a_res_q, a_res_d;
    logic [BIN_W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
    logic                op_valid_q, op_valid_d, disp_sel_q, disp_sel_d;
    logic [DW-1:0]       disp_bcd_q, disp_bcd_d;
    logic [CW-1:0]       disp_cnt_q, disp_cnt_d;

    logic                is_digit;
    logic [3:0]          digit;
    logic                key_next, key_clear, key_eq, key_bs;
    logic [BIN_W-1:0]    mac;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (key_code)
            4'd0:    digit = 4'd1;
            4'd1:    digit = 4'd2;
            4'd2:    digit = 4'd3;
            4'd4:    digit = 4'd4;
            4'd5:    digit = 4'd5;
            4'd6:    digit = 4'd6;
            4'd8:    digit = 4'd7;
            4'd9:    digit = 4'd8;
            4'd10:   digit = 4'd9;
            4'd13:   digit = 4'd0;
            default: is_digit = 1'b0;
        endcase
        is_digit = is_digit & key_pulse;
    end

    assign key_next  = key_pulse && (key_code == 4'd3);
    assign key_clear = key_pulse && (key_code == 4'd12);
    assign key_eq    = key_pulse && (key_code == 4'd14);
`ifdef KEYPAD_BACKSPACE_EN
    assign key_bs    = key_pulse && (key_code == 4'd7);
`else
    assign key_bs    = 1'b0;
`endif

    // One Horner step: acc*10 + next MSD-first digit, wrapping at BIN_W.
    assign mac = (acc_q << 3) + (acc_q << 1) + BIN_W'(conv_sh_q[2*DW-1 -: 4]);

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch.
        state_d   = state_q;
        a_bcd_d   = a_bcd_q;
        b_bcd_d   = b_bcd_q;
        a_cnt_d   = a_cnt_q;
        b_cnt_d   = b_cnt_q;
        conv_sh_d = conv_sh_q;
        step_d    = step_q;
        acc_d     = acc_q;
        a_res_d   = a_res_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;

        case (state_q)
            S_A: begin
                if (is_digit && a_cnt_q != CNT_MAX) begin
                    a_bcd_d = (a_bcd_q << 4) | DW'(digit);
                    a_cnt_d = a_cnt_q + 1'b1;
                end else if (key_next && a_cnt_q != '0) begin
                    state_d = S_B;
                end else if (key_bs && a_cnt_q != '0) begin
                    a_bcd_d = a_bcd_q >> 4;
                    a_cnt_d = a_cnt_q - 1'b1;
                end
            end
            S_B: begin
                if (is_digit && b_cnt_q != CNT_MAX) begin
                    b_bcd_d = (b_bcd_q << 4) | DW'(digit);
                    b_cnt_d = b_cnt_q + 1'b1;
                end else if (key_eq && b_cnt_q != '0) begin
                    state_d   = S_CONV;
                    conv_sh_d = {a_bcd_q, b_bcd_q};
                    step_d    = '0;
                    acc_d     = '0;
                end else if (key_bs && b_cnt_q != '0) begin
                    b_bcd_d = b_bcd_q >> 4;
                    b_cnt_d = b_cnt_q - 1'b1;
                end
            end
            S_CONV: begin
                conv_sh_d = conv_sh_q << 4;
                step_d    = step_q + 1'b1;
                if (step_q == STEP_A_LAST) begin
                    a_res_d = mac;
                    acc_d   = '0;
                end else begin
                    acc_d = mac;
                end
                if (step_q == STEP_LAST) begin
                    op_a_d  = a_res_q;
                    op_b_d  = mac;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (op_ready) begin
                    state_d = S_A;
                    a_bcd_d = '0;
                    b_bcd_d = '0;
                    a_cnt_d = '0;
                    b_cnt_d = '0;
                end
            end
            default: state_d = S_A;
        endcase

        if (key_clear && (state_q == S_A || state_q == S_B)) begin
            state_d = S_A;
            a_bcd_d = '0;
            b_bcd_d = '0;
            a_cnt_d = '0;
            b_cnt_d = '0;
        end

        // Outputs are registered copies of the next-state view.
        op_valid_d = (state_d == S_OUT);
        disp_sel_d = (state_d != S_A);
        disp_bcd_d = disp_sel_d ? b_bcd_d : a_bcd_d;
        disp_cnt_d = disp_sel_d ? b_cnt_d : a_cnt_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_A;
            a_bcd_q    <= '0;
            b_bcd_q    <= '0;
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            conv_sh_q  <= '0;
            step_q     <= '0;
            acc_q      <= '0;
            a_res_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            disp_sel_q <= 1'b0;
            disp_bcd_q <= '0;
            disp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            a_bcd_q    <= a_bcd_d;
            b_bcd_q    <= b_bcd_d;
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            conv_sh_q  <= conv_sh_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            a_res_q    <= a_res_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            disp_sel_q <= disp_sel_d;
            disp_bcd_q <= disp_bcd_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign disp_bcd = disp_bcd_q;
    assign disp_cnt = disp_cnt_q;
    assign disp_sel = disp_sel_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Testbench for keypad_operand_entry: table of single-key display checks plus
// hand-written conversion, handshake, saturation, backspace and reset sequences.
module tb_keypad_operand_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_code;
    logic        key_pulse;
    logic        op_ready;
    logic        op_valid;
    logic [9:0]  op_a, op_b;
    logic [11:0] disp_bcd;
    logic [1:0]  disp_cnt;
    logic        disp_sel;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_operand_entry dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_pulse(key_pulse),
        .op_ready(op_ready), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .disp_bcd(disp_bcd), .disp_cnt(disp_cnt), .disp_sel(disp_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [11:0] bcd;
        logic [1:0]  cnt;
        logic        sel;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_code  = c;
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
    endtask

    task automatic check_disp(input string name, input logic [11:0] bcd,
                              input logic [1:0] cnt, input logic sel);
        check({name, ".bcd"}, 32'(disp_bcd), 32'(bcd));
        check({name, ".cnt"}, 32'(disp_cnt), 32'(cnt));
        check({name, ".sel"}, 32'(disp_sel), 32'(sel));
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".valid"}, 32'(op_valid), 32'd0);
        check({name, ".op_a"}, 32'(op_a), 32'd0);
        check({name, ".op_b"}, 32'(op_b), 32'd0);
        check_disp(name, 12'h000, 2'd0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        key_code  = 4'd0;
        key_pulse = 1'b0;
        op_ready  = 1'b0;

        // Reset with key pulses arriving during reset
        @(negedge clk);
        key_code  = 4'd0;
        key_pulse = 1'b1;
        @(negedge clk);
        key_pulse = 1'b0;
        check_all_zero("reset");
        rst = 1'b0;

        // Single-key table: code, then expected display after that key
        vecs.push_back('{4'd14, 12'h000, 2'd0, 1'b0});  // # in S_A ignored
        vecs.push_back('{4'd3,  12'h000, 2'd0, 1'b0});  // A with no digits ignored
        vecs.push_back('{4'd11, 12'h000, 2'd0, 1'b0});
        vecs.push_back('{4'd0,  12'h001, 2'd1, 1'b0});
        vecs.push_back('{4'd1,  12'h012, 2'd2, 1'b0});
        vecs.push_back('{4'd2,  12'h123, 2'd3, 1'b0});
        vecs.push_back('{4'd9,  12'h123, 2'd3, 1'b0});  // full, ignored
        vecs.push_back('{4'd15, 12'h123, 2'd3, 1'b0});
        vecs.push_back('{4'd3,  12'h000, 2'd0, 1'b1});  // to S_B
        vecs.push_back('{4'd3,  12'h000, 2'd0, 1'b1});  // A in S_B ignored
        vecs.push_back('{4'd14, 12'h000, 2'd0, 1'b1});  // # with empty B ignored
        vecs.push_back('{4'd13, 12'h000, 2'd1, 1'b1});  // leading zero counts
        vecs.push_back('{4'd4,  12'h004, 2'd2, 1'b1});
        vecs.push_back('{4'd10, 12'h049, 2'd3, 1'b1});
        vecs.push_back('{4'd12, 12'h000, 2'd0, 1'b0});  // clear from S_B
        vecs.push_back('{4'd5,  12'h005, 2'd1, 1'b0});
        vecs.push_back('{4'd3,  12'h000, 2'd0, 1'b1});
        vecs.push_back('{4'd6,  12'h006, 2'd1, 1'b1});
        vecs.push_back('{4'd12, 12'h000, 2'd0, 1'b0});
        foreach (vecs[i]) begin
            press(vecs[i].code);
            check_disp($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].cnt, vecs[i].sel);
        end
        check("vec.valid", 32'(op_valid), 32'd0);

        // Normal flow: 123 A 45 #, op_ready low
        press(4'd0); press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        press(4'd14);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("flow.valid_E%0d", k), 32'(op_valid), (k == 6) ? 32'd1 : 32'd0);
        end
        check("flow.op_a", 32'(op_a), 32'd123);
        check("flow.op_b", 32'(op_b), 32'd45);
        check_disp("flow.disp", 12'h045, 2'd2, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k == 4) press(4'd12);  // clear while valid must not withdraw it
            else @(posedge clk);
            #1;
            check("hold.valid", 32'(op_valid), 32'd1);
            check("hold.op_a", 32'(op_a), 32'd123);
            check("hold.op_b", 32'(op_b), 32'd45);
        end
        // Handshake with a simultaneous key that must be ignored
        @(negedge clk);
        op_ready  = 1'b1;
        key_code  = 4'd0;
        key_pulse = 1'b1;
        @(posedge clk); #1;
        check("hs.valid", 32'(op_valid), 32'd0);
        check_disp("hs.disp", 12'h000, 2'd0, 1'b0);
        check("hs.op_a_hold", 32'(op_a), 32'd123);
        @(negedge clk);
        key_pulse = 1'b0;
        op_ready  = 1'b0;
        check_disp("hs.after", 12'h000, 2'd0, 1'b0);

        // Saturation, op_ready held high ahead of valid
        press(4'd10); press(4'd10); press(4'd10); press(4'd8);
        check_disp("sat.a", 12'h999, 2'd3, 1'b0);
        press(4'd3); press(4'd13); press(4'd13); press(4'd0);
        check_disp("sat.b", 12'h001, 2'd3, 1'b1);
        op_ready = 1'b1;
        press(4'd14);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check("sat.early_valid", 32'(op_valid), 32'd0);
        end
        @(posedge clk); #1;
        check("sat.valid", 32'(op_valid), 32'd1);
        check("sat.op_a", 32'(op_a), 32'd999);
        check("sat.op_b", 32'(op_b), 32'd1);
        @(posedge clk); #1;
        check("sat.done", 32'(op_valid), 32'd0);
        @(negedge clk);
        op_ready = 1'b0;

        // Backspace
        press(4'd0); press(4'd1); press(4'd7);
`ifdef KEYPAD_BACKSPACE_EN
        check_disp("bs", 12'h001, 2'd1, 1'b0);
        press(4'd7); press(4'd7);
        check_disp("bs.empty", 12'h000, 2'd0, 1'b0);
        press(4'd2); press(4'd3); press(4'd4); press(4'd7); press(4'd7);
        check_disp("bs.b", 12'h000, 2'd0, 1'b1);
`else
        check_disp("bs", 12'h012, 2'd2, 1'b0);
`endif
        press(4'd12);
        check_disp("bs.clr", 12'h000, 2'd0, 1'b0);

        // Reset in the middle of a conversion
        press(4'd8); press(4'd3); press(4'd1); press(4'd14);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("midrst.valid", 32'(op_valid), 32'd0);
        end
        check_all_zero("midrst.after");
        press(4'd4); press(4'd3); press(4'd5); press(4'd14);
        repeat (6) @(posedge clk);
        #1;
        check("re.valid", 32'(op_valid), 32'd1);
        check("re.op_a", 32'(op_a), 32'd4);
        check("re.op_b", 32'(op_b), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
